inject_scheduler: RTL



---
 rtl/inject_scheduler_pkg.sv | 69 ++++++
 rtl/inject_scheduler_fifo.sv | 65 ++++++
 rtl/inject_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/inject_scheduler_pkg.sv
// Shared flit layout, port codes and scheduler state encoding for the
// injection, ejection and permutation datapaths.
package inject_scheduler_pkg;

  localparam int FLIT_W      = 32;
  localparam int GOLD_BIT    = 0;
  localparam int VALID_BIT   = 1;
  localparam int INPORT_LSB  = 2;
  localparam int INPORT_MSB  = 3;
  localparam int OUTPORT_LSB = 4;
  localparam int OUTPORT_MSB = 6;
  localparam int SRC_LSB     = 7;
  localparam int SRC_MSB     = 10;
  localparam int DST_LSB     = 11;
  localparam int DST_MSB     = 14;
  localparam int SEQ_LSB     = 15;
  localparam int SEQ_MSB     = 19;
  localparam int PAYLOAD_LSB = 20;
  localparam int PAYLOAD_MSB = 31;

  localparam int SEQ_W     = SEQ_MSB - SEQ_LSB + 1;
  localparam int PAYLOAD_W = PAYLOAD_MSB - PAYLOAD_LSB + 1;
  localparam int ADDR_W    = SRC_MSB - SRC_LSB + 1;
  localparam int PORT_W    = OUTPORT_MSB - OUTPORT_LSB + 1;

  localparam logic [PORT_W-1:0] PORT_N     = 3'b000;
  localparam logic [PORT_W-1:0] PORT_E     = 3'b001;
  localparam logic [PORT_W-1:0] PORT_S     = 3'b010;
  localparam logic [PORT_W-1:0] PORT_W_DIR = 3'b011;
  localparam logic [PORT_W-1:0] PORT_LOCAL = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    STARVED = 2'd2
  } inj_state_e;

  // One buffered flit as the core hands it over, before stamping.
  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ADDR_W-1:0]    dest;
    logic [PORT_W-1:0]    outport;
    logic                 last;
  } inj_entry_t;

  localparam int ENTRY_W = $bits(inj_entry_t);

  function automatic logic [FLIT_W-1:0] stamp_flit(
    input logic [PORT_W-1:0]    outport,
    input logic [ADDR_W-1:0]    dest,
    input logic [PAYLOAD_W-1:0] payload,
    input logic [SEQ_W-1:0]     seq,
    input logic [ADDR_W-1:0]    src,
    input logic                 gold
  );
    logic [FLIT_W-1:0] f;
    f                            = '0;
    f[GOLD_BIT]                  = gold;
    f[VALID_BIT]                 = 1'b1;
    f[INPORT_MSB:INPORT_LSB]     = 2'b00;
    f[OUTPORT_MSB:OUTPORT_LSB]   = outport;
    f[SRC_MSB:SRC_LSB]           = src;
    f[DST_MSB:DST_LSB]           = dest;
    f[SEQ_MSB:SEQ_LSB]           = seq;
    f[PAYLOAD_MSB:PAYLOAD_LSB]   = payload;
    return f;
  endfunction

endpackage

// File: rtl/inject_scheduler_fifo.sv
// Synchronous FIFO with occupancy count; push is refused when full even if
// a pop happens on the same edge.
module inj_fifo #(
  parameter int  W     = 20,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inject_scheduler.sv
// Local injection front end: buffers core flits, stamps the head flit and
// requests the router, rotates the golden source and flags starvation.
module inject_scheduler
  import inject_scheduler_pkg::*;
#(
  parameter logic [3:0] NODE_ID      = 4'd0,
  parameter int         DEPTH        = 8,
  parameter int         EPOCH_LEN    = 64,
  parameter int         STARVE_LIMIT = 32,
  localparam int        CW           = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [2:0]    push_outport,
  input  logic [3:0]    push_dest,
  input  logic [11:0]   push_payload,
  input  logic          push_last,
  output logic [31:0]   inject_flit,
  output logic          inj_bit,
  input  logic          injection_status,
  output logic [3:0]    golden_src,
  output logic          starved,
  output logic [CW-1:0] fifo_count
);

  localparam int EW = $clog2(EPOCH_LEN);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Handshakes: a push transfers on an edge where push_valid && push_ready;
  // a flit leaves on an edge where inj_bit && injection_status. Neither side
  // may retract valid data, and status seen while inj_bit=0 is ignored.

  inj_state_e    state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [EW-1:0] epoch_q, epoch_d;
  logic [3:0]    golden_q, golden_d;
  logic [SW-1:0] starve_q, starve_d;

  inj_entry_t    push_entry;
  inj_entry_t    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_acc;
  logic          pop;
  logic [CW-1:0] count_after;

  assign push_entry = {push_payload, push_dest, push_outport, push_last};
  assign push_ready = !fifo_full;
  assign push_acc   = push_valid && !fifo_full;
  assign inj_bit    = (state_q != IDLE);
  assign starved    = (state_q == STARVED);
  assign golden_src = golden_q;
  assign pop        = inj_bit && injection_status && !fifo_empty;

  // Occupancy as it will be after this edge; lets a freshly pushed flit
  // request on the very next cycle and keeps back-to-back pops in REQ.
  assign count_after = fifo_count + CW'(push_acc) - CW'(pop);

  inj_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_acc),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    seq_d    = seq_q;
    if (pop) begin
      seq_d = head.last ? '0 : seq_q + SEQ_W'(1);
    end
    case (state_q)
      IDLE: begin
        starve_d = '0;
        if (count_after != '0) begin
          state_d = REQ;
        end
      end
      REQ, STARVED: begin
        if (pop) begin
          starve_d = '0;
          state_d  = (count_after != '0) ? REQ : IDLE;
        end else begin
          if (starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
          if (starve_d >= SW'(STARVE_LIMIT - 1)) begin
            state_d = STARVED;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        starve_d = '0;
      end
    endcase
  end

  always_comb begin
    epoch_d  = epoch_q + EW'(1);
    golden_d = golden_q;
    if (epoch_q == EW'(EPOCH_LEN - 1)) begin
      epoch_d  = '0;
      golden_d = golden_q + 4'd1;
    end
  end

  // Gold bit follows the live epoch, so a waiting flit can change colour.
  always_comb begin
    inject_flit = '0;
    if (inj_bit) begin
      inject_flit = stamp_flit(head.outport, head.dest, head.payload, seq_q,
                               NODE_ID, (golden_q == NODE_ID));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      seq_q    <= '0;
      epoch_q  <= '0;
      golden_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      epoch_q  <= epoch_d;
      golden_q <= golden_d;
      starve_q <= starve_d;
    end
  end

endmodule
